// File: rtl/miriscv_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : miriscv_loader_pkg
// Description : Shared state encoding and helpers for the program loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package miriscv_loader_pkg;

  localparam int STATE_W = 3;

  // Loader session states; the numeric values are visible on state_o.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_TIMEOUT  = 3'd5,
    ST_OVERFLOW = 3'd6
  } loader_state_e;

  // Reverse the byte order of a 32-bit word (endianness conversion).
  function automatic logic [31:0] byte_reverse(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/miriscv_watchdog.sv
//------------------------------------------------------------------------------
// Module      : miriscv_watchdog
// Description : Saturating run-cycle counter with limit detection. "expired"
//               flags the cycle whose edge will make count equal the limit, so
//               the owner can leave RUN on the same edge the count lands.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_watchdog (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic [31:0] count,
  output logic        expired
);

  logic [31:0] r_count;
  logic [31:0] w_next;

  // Saturate at all-ones rather than wrapping.
  assign w_next  = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
  assign expired = enable & ~clear & (w_next == limit);
  assign count   = r_count;

  // Counter: clear has priority, otherwise count while enabled.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/miriscv_prog_loader.sv
//------------------------------------------------------------------------------
// Module      : miriscv_prog_loader
// Description : Streams a program into instruction RAM, releases the core
//               from reset, and waits for completion under a watchdog.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_prog_loader
  import miriscv_loader_pkg::*;
#(
  parameter  int RAM_SIZE       = 512,
  parameter  int TIMEOUT_CYCLES = 300,
  parameter  int BYTE_SWAP      = 0,
  localparam int ADDR_W         = $clog2(RAM_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              load_valid_i,
  input  logic [31:0]       load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_n_o,
  input  logic              done_i,
  input  logic [31:0]       result_i,
  output logic [2:0]        state_o,
  output logic [31:0]       result_o,
  output logic [31:0]       cycles_o
);

  loader_state_e     r_state;
  logic [ADDR_W-1:0] r_word_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_rst_n;
  logic [31:0]       r_result;

  logic              w_handshake;
  logic              w_at_end;
  logic              w_overflow;
  logic              w_load_entry;
  logic              w_expired;
  logic [31:0]       w_wdata;

  assign w_handshake  = load_valid_i & (r_state == ST_LOAD);
  assign w_at_end     = (r_word_idx == ADDR_W'(RAM_SIZE - 1));
  // A non-final word arriving in the last RAM slot means the program does not fit.
  assign w_overflow   = w_handshake & ~load_last_i & w_at_end;
  assign w_load_entry = start_i & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                                   (r_state == ST_TIMEOUT) | (r_state == ST_OVERFLOW));

  if (BYTE_SWAP == 1) begin : g_swap
    assign w_wdata = byte_reverse(load_data_i);
  end else begin : g_pass
    assign w_wdata = load_data_i;
  end

  // Run-cycle counter, zeroed on both LOAD entry and RUN entry (from FLUSH).
  miriscv_watchdog u_watchdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear   (w_load_entry | (r_state == ST_FLUSH)),
    .enable  (r_state == ST_RUN),
    .limit   (32'(TIMEOUT_CYCLES)),
    .count   (cycles_o),
    .expired (w_expired)
  );

  // Session FSM with registered RAM write port, core reset and result.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_word_idx   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rst_n <= 1'b0;
      r_result     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_TIMEOUT, ST_OVERFLOW: begin
          if (start_i) begin
            r_state    <= ST_LOAD;
            r_word_idx <= '0;
            r_result   <= '0;
          end
        end
        ST_LOAD: begin
          if (w_overflow) begin
            r_state <= ST_OVERFLOW;
          end else if (w_handshake) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_idx;
            r_mem_wdata <= w_wdata;
            r_word_idx  <= r_word_idx + ADDR_W'(1);
            if (load_last_i) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          r_state      <= ST_RUN;
          r_core_rst_n <= 1'b1;
        end
        ST_RUN: begin
          // Completion wins over a watchdog expiry in the same cycle.
          if (done_i) begin
            r_state      <= ST_DONE;
            r_result     <= result_i;
            r_core_rst_n <= 1'b0;
          end else if (w_expired) begin
            r_state      <= ST_TIMEOUT;
            r_core_rst_n <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_core_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o = (r_state == ST_LOAD);
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign core_rst_n_o = r_core_rst_n;
  assign state_o      = r_state;
  assign result_o     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_miriscv_prog_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_miriscv_prog_loader
// Description : Directed bench for the program loader. One instance with a
//               4-word RAM and one with byte swapping share the same stimulus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_miriscv_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, load_valid, load_last, done;
  logic [31:0] load_data, result_in;

  logic        ready, mem_we, core_rst_n;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata, result, cycles;
  logic [2:0]  state;

  logic        sw_ready, sw_mem_we, sw_core_rst_n;
  logic [8:0]  sw_mem_addr;
  logic [31:0] sw_mem_wdata, sw_result, sw_cycles;
  logic [2:0]  sw_state;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          sw_addr_q[$];
  logic [31:0] sw_data_q[$];
  logic        core_seen_high;

  always #5 clk = ~clk;

  miriscv_prog_loader #(.RAM_SIZE(4), .TIMEOUT_CYCLES(300), .BYTE_SWAP(0)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
    .load_ready_o(ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .core_rst_n_o(core_rst_n), .done_i(done), .result_i(result_in),
    .state_o(state), .result_o(result), .cycles_o(cycles)
  );

  miriscv_prog_loader #(.RAM_SIZE(512), .TIMEOUT_CYCLES(300), .BYTE_SWAP(1)) u_dut_sw (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
    .load_ready_o(sw_ready), .mem_we_o(sw_mem_we), .mem_addr_o(sw_mem_addr), .mem_wdata_o(sw_mem_wdata),
    .core_rst_n_o(sw_core_rst_n), .done_i(done), .result_i(result_in),
    .state_o(sw_state), .result_o(sw_result), .cycles_o(sw_cycles)
  );

  // Record every RAM write and whether the core was ever released.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (sw_mem_we) begin
      sw_addr_q.push_back(int'(sw_mem_addr));
      sw_data_q.push_back(sw_mem_wdata);
    end
    if (core_rst_n) core_seen_high = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete();
    sw_addr_q.delete(); sw_data_q.delete();
    core_seen_high = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; done = 1'b0; result_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", state); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", ready); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 2'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'd0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    vectors++; if (core_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_core got %b want 0", core_rst_n); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL rst_result got %h want 0", result); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL rst_cycles got %0d want 0", cycles); end
    vectors++; if (sw_result !== 32'd0) begin miscompares++; $display("FAIL rst_sw_result got %h want 0", sw_result); end
    // done_i outside RUN must not capture a result
    done = 1'b1; result_in = 32'h5; tick(); done = 1'b0; result_in = '0;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL idle_done_state got %0d want 0", state); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL idle_done_result got %h want 0", result); end
  endtask

  task automatic test_load_run();
    logic [31:0] prog [3];
    prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113; prog[2] = 32'h0000_0013;
    do_reset();
    pulse_start();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL load_ready got %b want 1", ready); end
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = prog[i]; load_last = (i == 2); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL flush_state got %0d want 2", state); end
    vectors++; if (core_rst_n !== 1'b0) begin miscompares++; $display("FAIL flush_core got %b want 0", core_rst_n); end
    tick();
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL run_state got %0d want 3", state); end
    vectors++; if (core_rst_n !== 1'b1) begin miscompares++; $display("FAIL run_core got %b want 1", core_rst_n); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL run_cycles0 got %0d want 0", cycles); end
    // start_i mid-run must be ignored
    for (int i = 0; i < 9; i++) begin
      start = (i == 3); tick();
    end
    start = 1'b0;
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL run_start_ign got %0d want 3", state); end
    vectors++; if (cycles !== 32'd9) begin miscompares++; $display("FAIL run_cycles9 got %0d want 9", cycles); end
    done = 1'b1; result_in = 32'd1; tick(); done = 1'b0; result_in = '0;
    vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL done_state got %0d want 4", state); end
    vectors++; if (result !== 32'd1) begin miscompares++; $display("FAIL done_result got %h want 1", result); end
    vectors++; if (cycles !== 32'd10) begin miscompares++; $display("FAIL done_cycles got %0d want 10", cycles); end
    vectors++; if (core_rst_n !== 1'b0) begin miscompares++; $display("FAIL done_core got %b want 0", core_rst_n); end
    vectors++; if (wr_addr_q.size() !== 3) begin miscompares++; $display("FAIL load_nwrites got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      vectors++; if (wr_addr_q[i] !== i || wr_data_q[i] !== prog[i]) begin
        miscompares++; $display("FAIL load_write%0d got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], i, prog[i]);
      end
    end
    tick(); tick();
    vectors++; if (cycles !== 32'd10) begin miscompares++; $display("FAIL done_hold got %0d want 10", cycles); end
    pulse_start();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL reload_state got %0d want 1", state); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL reload_cycles got %0d want 0", cycles); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reload_result got %h want 0", result); end
  endtask

  task automatic test_byte_swap();
    do_reset();
    pulse_start();
    load_valid = 1'b1; load_data = 32'h1122_3344; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    vectors++; if (sw_mem_we !== 1'b1 || sw_mem_addr !== 9'd0) begin miscompares++; $display("FAIL swap_we got %b@%0d want 1@0", sw_mem_we, sw_mem_addr); end
    vectors++; if (sw_mem_wdata !== 32'h4433_2211) begin miscompares++; $display("FAIL swap_data got %h want 44332211", sw_mem_wdata); end
    vectors++; if (mem_wdata !== 32'h1122_3344) begin miscompares++; $display("FAIL noswap_data got %h want 11223344", mem_wdata); end
    vectors++; if (sw_state !== 3'd2 || sw_ready !== 1'b0) begin miscompares++; $display("FAIL swap_flush got %0d/%b want 2/0", sw_state, sw_ready); end
    tick();
    vectors++; if (sw_mem_we !== 1'b0) begin miscompares++; $display("FAIL swap_we_pulse got %b want 0", sw_mem_we); end
    vectors++; if (sw_addr_q.size() !== 1) begin miscompares++; $display("FAIL swap_nwrites got %0d want 1", sw_addr_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse_start();
    load_valid = 1'b1; load_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_data = 32'hA0 + i; tick();
    end
    load_valid = 1'b0;
    tick(); tick();
    vectors++; if (state !== 3'd6) begin miscompares++; $display("FAIL ovf_state got %0d want 6", state); end
    vectors++; if (ready !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL ovf_idle got %b/%b want 0/0", ready, mem_we); end
    vectors++; if (wr_addr_q.size() !== 3) begin miscompares++; $display("FAIL ovf_nwrites got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      vectors++; if (wr_addr_q[i] !== i || wr_data_q[i] !== 32'hA0 + i) begin
        miscompares++; $display("FAIL ovf_write%0d got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], i, 32'hA0 + i);
      end
    end
    vectors++; if (core_seen_high !== 1'b0) begin miscompares++; $display("FAIL ovf_core got %b want 0", core_seen_high); end
    // Last word landing in the final slot is a normal completion
    pulse_start();
    clear_logs();
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data = 32'hB0 + i; load_last = (i == 3); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL edge_state got %0d want 2", state); end
    tick();
    vectors++; if (wr_addr_q.size() !== 4) begin miscompares++; $display("FAIL edge_nwrites got %0d want 4", wr_addr_q.size()); end
    else begin
      vectors++; if (wr_addr_q[3] !== 3 || wr_data_q[3] !== 32'hB3) begin miscompares++; $display("FAIL edge_write3 got %0d/%h want 3/b3", wr_addr_q[3], wr_data_q[3]); end
    end
    vectors++; if (state !== 3'd3 || core_rst_n !== 1'b1) begin miscompares++; $display("FAIL edge_run got %0d/%b want 3/1", state, core_rst_n); end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    load_valid = 1'b1; load_data = 32'h13; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    repeat (299) tick();
    vectors++; if (state !== 3'd3 || cycles !== 32'd299) begin miscompares++; $display("FAIL to_pre got %0d/%0d want 3/299", state, cycles); end
    tick();
    vectors++; if (state !== 3'd5) begin miscompares++; $display("FAIL to_state got %0d want 5", state); end
    vectors++; if (cycles !== 32'd300 || sw_cycles !== 32'd300) begin miscompares++; $display("FAIL to_cycles got %0d/%0d want 300", cycles, sw_cycles); end
    vectors++; if (core_rst_n !== 1'b0 || sw_core_rst_n !== 1'b0) begin miscompares++; $display("FAIL to_core got %b/%b want 0", core_rst_n, sw_core_rst_n); end
    repeat (3) tick();
    vectors++; if (cycles !== 32'd300) begin miscompares++; $display("FAIL to_hold got %0d want 300", cycles); end
    // Rerun with done_i exactly on the limit cycle
    pulse_start();
    vectors++; if (state !== 3'd1 || cycles !== 32'd0) begin miscompares++; $display("FAIL to_reload got %0d/%0d want 1/0", state, cycles); end
    load_valid = 1'b1; load_data = 32'h13; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    repeat (299) tick();
    done = 1'b1; result_in = 32'hCAFE_0001; tick(); done = 1'b0; result_in = '0;
    vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL to_prio_state got %0d want 4", state); end
    vectors++; if (cycles !== 32'd300) begin miscompares++; $display("FAIL to_prio_cycles got %0d want 300", cycles); end
    vectors++; if (result !== 32'hCAFE_0001) begin miscompares++; $display("FAIL to_prio_result got %h want cafe0001", result); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    pulse_start();
    load_valid = 1'b1; load_last = 1'b0;
    load_data = 32'hC0; tick();
    load_data = 32'hC1; tick();
    load_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 2'd1) begin miscompares++; $display("FAIL mid_pending got %b@%0d want 1@1", mem_we, mem_addr); end
    rst_n = 1'b0; tick();
    vectors++; if (state !== 3'd0 || ready !== 1'b0) begin miscompares++; $display("FAIL mid_state got %0d/%b want 0/0", state, ready); end
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 32'd0) begin
      miscompares++; $display("FAIL mid_wport got %b/%0d/%h want 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    vectors++; if (core_rst_n !== 1'b0 || result !== 32'd0 || cycles !== 32'd0) begin
      miscompares++; $display("FAIL mid_outs got %b/%h/%0d want 0/0/0", core_rst_n, result, cycles);
    end
    tick(); rst_n = 1'b1; tick();
    vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL mid_nwrites got %0d want 2", wr_addr_q.size()); end
    clear_logs();
    pulse_start();
    load_valid = 1'b1; load_data = 32'hD0; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    vectors++; if (wr_addr_q.size() !== 1) begin miscompares++; $display("FAIL restart_nwrites got %0d want 1", wr_addr_q.size()); end
    else begin
      vectors++; if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'hD0) begin miscompares++; $display("FAIL restart_write got %0d/%h want 0/d0", wr_addr_q[0], wr_data_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_byte_swap();
    test_overflow();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

`default_nettype wire
